// File: rtl/sd_cmd_pkg.sv
// SD CMD-line shared types and constants.
// Used by the CMD receive sequencer and CRC7 engines.
package sd_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE       = 2'd0,
    CMD_WAIT_START = 2'd1,
    CMD_RECEIVE    = 2'd2,
    CMD_DONE       = 2'd3
  } cmd_rx_state_t;

  localparam logic [6:0] CRC7_POLY   = 7'h09;
  localparam int         RESP_LEN_R1 = 48;

endpackage

// File: rtl/crc7_serial.sv
// Serial CRC7 LFSR (x^7+x^3+1), one bit per shift_en.
// Ports: clk, reset (sync), clear, shift_en, din, crc[6:0].
module crc7_serial
  import sd_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] r_crc;
  logic       w_fb;

  assign w_fb = din ^ r_crc[6];
  assign crc  = r_crc;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_crc <= 7'h00;
    end else if (shift_en) begin
      r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/cmd_resp_rx_ctrl.sv
// SD CMD response receiver: start-bit detect, MSB-first
// deserialise, CRC7/end-bit check, N_CR timeout.
// Ports: clk, reset (sync), enable (sample strobe), cmd_in,
// arm, busy, resp_valid/resp_ready handshake, resp_data,
// crc_ok, end_ok, timeout.
module cmd_resp_rx_ctrl
  import sd_cmd_pkg::*;
#(
  parameter int RESP_BITS = RESP_LEN_R1,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 cmd_in,
  input  logic                 arm,
  output logic                 busy,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [RESP_BITS-1:0] resp_data,
  output logic                 crc_ok,
  output logic                 end_ok,
  output logic                 timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(RESP_BITS + 1);

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT);
  localparam logic [CW-1:0] BIT_LAST = CW'(RESP_BITS);
  localparam logic [CW-1:0] CRC_LAST = CW'(RESP_BITS - 8);

  cmd_rx_state_t        r_state;
  logic [TW-1:0]        r_tcnt;
  logic [CW-1:0]        r_bcnt;
  logic [RESP_BITS-1:0] r_sr;
  logic                 r_crc_ok;
  logic                 r_end_ok;
  logic                 r_timeout;

  logic [TW-1:0]        w_tcnt_nxt;
  logic [CW-1:0]        w_bcnt_nxt;
  logic [RESP_BITS-1:0] w_sr_nxt;
  logic [6:0]           w_crc;
  logic                 w_crc_clr;
  logic                 w_crc_en;
  logic                 w_in_wait;
  logic                 w_in_recv;

  assign w_tcnt_nxt = r_tcnt + 1'b1;
  assign w_bcnt_nxt = r_bcnt + 1'b1;
  assign w_sr_nxt   = {r_sr[RESP_BITS-2:0], cmd_in};

  assign w_in_wait = (r_state == CMD_WAIT_START);
  assign w_in_recv = (r_state == CMD_RECEIVE);

  // The sampled bit is number r_bcnt+1; only the header and
  // payload (bits 1..RESP_BITS-8) go into the CRC.
  assign w_crc_clr = (r_state == CMD_IDLE);
  assign w_crc_en  = enable &
                     ((w_in_wait & ~cmd_in) |
                      (w_in_recv & (r_bcnt < CRC_LAST)));

  crc7_serial u_crc (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_crc_clr),
    .shift_en (w_crc_en),
    .din      (cmd_in),
    .crc      (w_crc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= CMD_IDLE;
      r_tcnt    <= '0;
      r_bcnt    <= '0;
      r_sr      <= '0;
      r_crc_ok  <= 1'b0;
      r_end_ok  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        CMD_IDLE: begin
          r_tcnt    <= '0;
          r_bcnt    <= '0;
          r_sr      <= '0;
          r_crc_ok  <= 1'b0;
          r_end_ok  <= 1'b0;
          r_timeout <= 1'b0;
          if (arm) r_state <= CMD_WAIT_START;
        end
        CMD_WAIT_START: begin
          if (enable) begin
            if (!cmd_in) begin
              r_sr    <= w_sr_nxt;
              r_bcnt  <= CW'(1);
              r_state <= CMD_RECEIVE;
            end else begin
              r_tcnt <= w_tcnt_nxt;
              if (w_tcnt_nxt == TO_LAST) begin
                r_timeout <= 1'b1;
                r_state   <= CMD_DONE;
              end
            end
          end
        end
        CMD_RECEIVE: begin
          if (enable) begin
            r_sr   <= w_sr_nxt;
            r_bcnt <= w_bcnt_nxt;
            // On the last bit, r_sr[6:0] becomes resp_data[7:1].
            if (w_bcnt_nxt == BIT_LAST) begin
              r_crc_ok <= (w_crc == r_sr[6:0]);
              r_end_ok <= cmd_in;
              r_state  <= CMD_DONE;
            end
          end
        end
        CMD_DONE: begin
          if (resp_ready) r_state <= CMD_IDLE;
        end
      endcase
    end
  end

  assign busy       = (r_state != CMD_IDLE);
  assign resp_valid = (r_state == CMD_DONE);
  assign resp_data  = r_sr;
  assign crc_ok     = r_crc_ok;
  assign end_ok     = r_end_ok;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_cmd_resp_rx_ctrl.sv
// Self-checking bench for cmd_resp_rx_ctrl.
// Scoreboard queue of expected frames, per-scenario tasks.
module tb_cmd_resp_rx_ctrl;

  localparam int RB = 48;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          cmd_in;
  logic          arm;
  logic          busy;
  logic          resp_valid;
  logic          resp_ready;
  logic [RB-1:0] resp_data;
  logic          crc_ok;
  logic          end_ok;
  logic          timeout;

  always #5 clk = ~clk;

  cmd_resp_rx_ctrl #(
    .RESP_BITS (RB),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cmd_in     (cmd_in),
    .arm        (arm),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .crc_ok     (crc_ok),
    .end_ok     (end_ok),
    .timeout    (timeout)
  );

  typedef struct {
    logic [RB-1:0] data;
    logic          c;
    logic          e;
    logic          t;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic idle_high(input int n);
    enable = 1'b1;
    cmd_in = 1'b1;
    repeat (n) tick();
  endtask

  // edges counts clock edges from the first one at which the
  // start bit is on the line.
  task automatic drive_frame(input logic [RB-1:0] f,
                             input bit half,
                             output int edges);
    edges = 0;
    for (int i = RB - 1; i >= 0; i--) begin
      cmd_in = f[i];
      if (half) begin
        enable = 1'b0;
        tick();
        edges++;
      end
      enable = 1'b1;
      tick();
      edges++;
    end
    enable = 1'b1;
    cmd_in = 1'b1;
  endtask

  task automatic collect(input int e0, output int lat,
                         output logic [RB+2:0] obs,
                         output bit ok);
    lat = e0;
    obs = '0;
    ok  = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (resp_valid) begin
        obs = {resp_data, crc_ok, end_ok, timeout};
        ok  = 1'b1;
        break;
      end
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    logic [RB+5:0] got;
    reset      = 1'b1;
    arm        = 1'b1;
    enable     = 1'b1;
    cmd_in     = 1'b1;
    resp_ready = 1'b1;
    tick();
    tick();
    got = {busy, resp_valid, resp_data, crc_ok, end_ok, timeout};
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0", got);
    end
    reset = 1'b0;
    arm   = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_arm_discard: busy %b want 0", busy);
    end
  endtask

  task automatic test_basic();
    exp_t ex;
    int e, lat;
    logic [RB+2:0] obs;
    bit ok;
    enable = 1'b0;
    do_arm();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL arm_busy: busy %b want 1", busy);
    end
    idle_high(3);
    exp_q.push_back('{48'h48000001AA87, 1'b1, 1'b1, 1'b0, 48});
    drive_frame(48'h48000001AA87, 1'b0, e);
    collect(e, lat, obs, ok);
    ex = exp_q.pop_front();
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL basic_valid: no resp_valid within bound");
    end else if (obs !== {ex.data, ex.c, ex.e, ex.t}) begin
      miscompares++;
      $display("FAIL basic_result: got %h want %h",
               obs, {ex.data, ex.c, ex.e, ex.t});
    end
    vectors++;
    if (lat != ex.lat) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d want %0d", lat, ex.lat);
    end
    tick();
    vectors++;
    if ({busy, resp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL basic_release: busy/valid %b want 00",
               {busy, resp_valid});
    end
  endtask

  task automatic test_crc_flags();
    logic [RB-1:0] fr [2];
    logic          ec [2];
    logic          ee [2];
    exp_t ex;
    int e, lat;
    logic [RB+2:0] obs;
    bit ok;
    fr[0] = 48'h400000000097; ec[0] = 1'b0; ee[0] = 1'b1;
    fr[1] = 48'h400000000094; ec[1] = 1'b1; ee[1] = 1'b0;
    for (int n = 0; n < 2; n++) begin
      do_arm();
      idle_high(1 + n);
      exp_q.push_back('{fr[n], ec[n], ee[n], 1'b0, 48});
      drive_frame(fr[n], 1'b0, e);
      collect(e, lat, obs, ok);
      ex = exp_q.pop_front();
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL crc_valid%0d: no resp_valid", n);
      end else if (obs !== {ex.data, ex.c, ex.e, ex.t}) begin
        miscompares++;
        $display("FAIL crc_result%0d: got %h want %h",
                 n, obs, {ex.data, ex.c, ex.e, ex.t});
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    exp_t ex;
    int lat;
    logic [RB+2:0] obs;
    bit ok;
    enable = 1'b1;
    cmd_in = 1'b1;
    exp_q.push_back('{'0, 1'b0, 1'b0, 1'b1, TO});
    do_arm();
    collect(0, lat, obs, ok);
    ex = exp_q.pop_front();
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL timeout_valid: no resp_valid");
    end else if (obs !== {ex.data, ex.c, ex.e, ex.t}) begin
      miscompares++;
      $display("FAIL timeout_result: got %h want %h",
               obs, {ex.data, ex.c, ex.e, ex.t});
    end
    vectors++;
    if (lat != ex.lat) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d want %0d", lat, ex.lat);
    end
    tick();
  endtask

  task automatic test_enable_gating();
    exp_t ex;
    int e, lat;
    logic [RB+2:0] obs;
    bit ok;
    do_arm();
    idle_high(2);
    exp_q.push_back('{48'h400000000095, 1'b1, 1'b1, 1'b0, 96});
    drive_frame(48'h400000000095, 1'b1, e);
    collect(e, lat, obs, ok);
    ex = exp_q.pop_front();
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL gate_valid: no resp_valid");
    end else if (obs !== {ex.data, ex.c, ex.e, ex.t}) begin
      miscompares++;
      $display("FAIL gate_result: got %h want %h",
               obs, {ex.data, ex.c, ex.e, ex.t});
    end
    vectors++;
    if (lat != ex.lat) begin
      miscompares++;
      $display("FAIL gate_latency: got %0d want %0d", lat, ex.lat);
    end
    tick();
  endtask

  task automatic test_hold_ready();
    exp_t ex;
    int e, lat;
    logic [RB+2:0] obs;
    logic [RB+4:0] held;
    bit ok;
    resp_ready = 1'b0;
    do_arm();
    idle_high(1);
    exp_q.push_back('{48'h48000001AA87, 1'b1, 1'b1, 1'b0, 48});
    drive_frame(48'h48000001AA87, 1'b0, e);
    collect(e, lat, obs, ok);
    ex = exp_q.pop_front();
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL hold_valid: no resp_valid");
    end else if (obs !== {ex.data, ex.c, ex.e, ex.t}) begin
      miscompares++;
      $display("FAIL hold_result: got %h want %h",
               obs, {ex.data, ex.c, ex.e, ex.t});
    end
    for (int c = 0; c < 10; c++) begin
      arm    = (c == 4);
      cmd_in = c[0];
      tick();
      held = {busy, resp_valid, resp_data, crc_ok, end_ok, timeout};
      vectors++;
      if (held !== {2'b11, ex.data, ex.c, ex.e, ex.t}) begin
        miscompares++;
        $display("FAIL hold_stable%0d: got %h want %h", c, held,
                 {2'b11, ex.data, ex.c, ex.e, ex.t});
      end
    end
    resp_ready = 1'b1;
    arm        = 1'b1;
    cmd_in     = 1'b1;
    tick();
    arm = 1'b0;
    vectors++;
    if ({busy, resp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL hold_release: busy/valid %b want 00",
               {busy, resp_valid});
    end
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_arm_ignored: busy %b want 0", busy);
    end
  endtask

  task automatic test_reset_midframe();
    logic [RB-1:0] f;
    logic [RB+5:0] got;
    exp_t ex;
    int e, lat;
    logic [RB+2:0] obs;
    bit ok;
    f = 48'h48000001AA87;
    do_arm();
    idle_high(2);
    for (int i = RB - 1; i >= RB - 20; i--) begin
      cmd_in = f[i];
      tick();
    end
    reset = 1'b1;
    arm   = 1'b1;
    tick();
    got = {busy, resp_valid, resp_data, crc_ok, end_ok, timeout};
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL midreset_state: got %h want 0", got);
    end
    reset  = 1'b0;
    arm    = 1'b0;
    cmd_in = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_arm: busy %b want 0", busy);
    end
    do_arm();
    idle_high(1);
    exp_q.push_back('{f, 1'b1, 1'b1, 1'b0, 48});
    drive_frame(f, 1'b0, e);
    collect(e, lat, obs, ok);
    ex = exp_q.pop_front();
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rearm_valid: no resp_valid");
    end else if (obs !== {ex.data, ex.c, ex.e, ex.t}) begin
      miscompares++;
      $display("FAIL rearm_result: got %h want %h",
               obs, {ex.data, ex.c, ex.e, ex.t});
    end
    vectors++;
    if (lat != ex.lat) begin
      miscompares++;
      $display("FAIL rearm_latency: got %0d want %0d", lat, ex.lat);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    cmd_in     = 1'b1;
    arm        = 1'b0;
    resp_ready = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_crc_flags();
    test_timeout();
    test_enable_gating();
    test_hold_ready();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
